// File: rtl/prog_loader.sv
// Streaming program loader: takes a length byte, N instruction bytes and a checksum
// byte, writes the instructions into instruction memory and releases the CPU on success.
module prog_loader #(
  parameter logic [7:0] BASE_ADDR = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       imem_we,
  output logic [7:0] imem_addr,
  output logic [7:0] imem_wdata,
  output logic       cpu_reset,
  output logic       done,
  output logic       error
);

  typedef enum logic [2:0] {IDLE, LEN, DATA, CSUM, DONE, ERR} state_t;

  state_t     state_q, state_d;
  logic [7:0] len_q, len_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] sum_q, sum_d;
  logic       we_q, we_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       accept;

  assign in_ready = (state_q == LEN) || (state_q == DATA) || (state_q == CSUM);
  assign accept   = in_valid && in_ready;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d = LEN;
          len_d   = 8'h00;
          cnt_d   = 8'h00;
          sum_d   = 8'h00;
        end
      end
      LEN: begin
        if (accept) begin
          if (in_data == 8'h00) begin
            state_d = ERR;
          end else begin
            len_d   = in_data;
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (accept) begin
          // Write is registered: it appears on the outputs the cycle after acceptance.
          we_d    = 1'b1;
          addr_d  = BASE_ADDR + cnt_q;
          wdata_d = in_data;
          sum_d   = sum_q + in_data;
          cnt_d   = cnt_q + 8'd1;
          if (cnt_q == len_q - 8'd1) state_d = CSUM;
        end
      end
      CSUM: begin
        if (accept) state_d = (in_data == sum_q) ? DONE : ERR;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      len_q   <= 8'h00;
      cnt_q   <= 8'h00;
      sum_q   <= 8'h00;
      we_q    <= 1'b0;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  // The CPU is held whenever reset is asserted, even before the first clock edge.
  assign cpu_reset  = reset || (state_q != DONE);
  assign done       = (state_q == DONE);
  assign error      = (state_q == ERR);

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: two instances (base 00 and base FE) share the stimulus;
// writes are collected per instance and compared with hand-computed expectations.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       reset, start, in_valid;
  logic [7:0] in_data;

  logic       rdy0, we0, cpur0, done0, err0;
  logic [7:0] addr0, wd0;
  logic       rdy1, we1, cpur1, done1, err1;
  logic [7:0] addr1, wd1;

  int checks = 0;
  int errors = 0;

  logic [15:0] wq0[$];
  logic [15:0] wq1[$];

  always #5 clk = ~clk;

  prog_loader #(.BASE_ADDR(8'h00)) dut0 (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy0), .imem_we(we0), .imem_addr(addr0), .imem_wdata(wd0),
    .cpu_reset(cpur0), .done(done0), .error(err0)
  );

  prog_loader #(.BASE_ADDR(8'hFE)) dut1 (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy1), .imem_we(we1), .imem_addr(addr1), .imem_wdata(wd1),
    .cpu_reset(cpur1), .done(done1), .error(err1)
  );

  // Write strobes last one cycle, so a negedge sample captures each write once.
  always @(negedge clk) begin
    if (we0) wq0.push_back({addr0, wd0});
    if (we1) wq1.push_back({addr1, wd1});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the byte is accepted at the following posedge.
  task automatic send(input logic [7:0] b);
    check("ready_on_send", 32'(rdy0), 32'd1);
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_q();
    wq0.delete();
    wq1.delete();
  endtask

  initial begin
    reset = 1'b1; start = 1'b1; in_valid = 1'b1; in_data = 8'h55;
    idle(3);
    // Reset wins over start and handshake.
    check("rst_ready", 32'(rdy0), 32'd0);
    check("rst_we", 32'(we0), 32'd0);
    check("rst_addr", 32'(addr0), 32'h00);
    check("rst_wdata", 32'(wd0), 32'h00);
    check("rst_cpu_reset", 32'(cpur0), 32'd1);
    check("rst_done", 32'(done0), 32'd0);
    check("rst_error", 32'(err0), 32'd0);
    start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    reset = 1'b0;
    idle(2);
    check("idle_ready", 32'(rdy0), 32'd0);
    check("idle_cpu_reset", 32'(cpur0), 32'd1);
    clear_q();

    // Nominal load.
    pulse_start();
    send(8'h03); send(8'h41); send(8'h8A); send(8'hC5); send(8'h90);
    check("nom_done", 32'(done0), 32'd1);
    check("nom_error", 32'(err0), 32'd0);
    check("nom_cpu_reset", 32'(cpur0), 32'd0);
    check("nom_ready", 32'(rdy0), 32'd0);
    idle(1);
    check("nom_nwrites", 32'(wq0.size()), 32'd3);
    check("nom_w0", 32'(wq0[0]), 32'h0041);
    check("nom_w1", 32'(wq0[1]), 32'h018A);
    check("nom_w2", 32'(wq0[2]), 32'h02C5);
    clear_q();

    // Bad checksum.
    pulse_start();
    check("start_clears_done", 32'(done0), 32'd0);
    check("start_holds_cpu", 32'(cpur0), 32'd1);
    send(8'h03); send(8'h41); send(8'h8A); send(8'hC5); send(8'h91);
    check("bad_error", 32'(err0), 32'd1);
    check("bad_done", 32'(done0), 32'd0);
    check("bad_cpu_reset", 32'(cpur0), 32'd1);
    check("bad_ready", 32'(rdy0), 32'd0);
    idle(1);
    check("bad_nwrites", 32'(wq0.size()), 32'd3);
    check("bad_w2", 32'(wq0[2]), 32'h02C5);
    clear_q();

    // Zero length, then a good load.
    pulse_start();
    send(8'h00);
    check("zero_error", 32'(err0), 32'd1);
    check("zero_done", 32'(done0), 32'd0);
    idle(2);
    check("zero_nwrites", 32'(wq0.size()), 32'd0);
    pulse_start();
    check("zero_restart_error", 32'(err0), 32'd0);
    send(8'h03); send(8'h41); send(8'h8A); send(8'hC5); send(8'h90);
    check("zero_reload_done", 32'(done0), 32'd1);
    idle(1);
    check("zero_reload_nwrites", 32'(wq0.size()), 32'd3);
    clear_q();

    // Gaps every other cycle; a stray start mid-load must be ignored.
    pulse_start();
    send(8'h02); idle(1);
    send(8'h10);
    start = 1'b1; idle(1); start = 1'b0;
    check("gap_addr_hold", 32'(addr0), 32'h00);
    send(8'h20); idle(1);
    send(8'h30);
    check("gap_done", 32'(done0), 32'd1);
    idle(1);
    check("gap_nwrites", 32'(wq0.size()), 32'd2);
    check("gap_w0", 32'(wq0[0]), 32'h0010);
    check("gap_w1", 32'(wq0[1]), 32'h0120);
    clear_q();

    // Address wrap on the FE-based instance.
    pulse_start();
    send(8'h03); send(8'h01); send(8'h02); send(8'h03); send(8'h06);
    check("wrap_done", 32'(done1), 32'd1);
    check("wrap_error", 32'(err1), 32'd0);
    idle(1);
    check("wrap_nwrites", 32'(wq1.size()), 32'd3);
    check("wrap_w0", 32'(wq1[0]), 32'hFE01);
    check("wrap_w1", 32'(wq1[1]), 32'hFF02);
    check("wrap_w2", 32'(wq1[2]), 32'h0003);
    clear_q();

    // Reset mid-DATA after the second of four data bytes.
    pulse_start();
    send(8'h04); send(8'h0A); send(8'h0B);
    reset = 1'b1;
    idle(1);
    check("mid_ready", 32'(rdy0), 32'd0);
    check("mid_we", 32'(we0), 32'd0);
    check("mid_addr", 32'(addr0), 32'h00);
    check("mid_wdata", 32'(wd0), 32'h00);
    check("mid_cpu_reset", 32'(cpur0), 32'd1);
    check("mid_done", 32'(done0), 32'd0);
    check("mid_error", 32'(err0), 32'd0);
    reset = 1'b0;
    idle(1);
    check("mid_post_we", 32'(we0), 32'd0);
    check("mid_nwrites", 32'(wq0.size()), 32'd2);
    clear_q();
    pulse_start();
    send(8'h02); send(8'h11); send(8'h22); send(8'h33);
    check("mid_reload_done", 32'(done0), 32'd1);
    idle(1);
    check("mid_reload_nwrites", 32'(wq0.size()), 32'd2);
    check("mid_reload_w0", 32'(wq0[0]), 32'h0011);
    check("mid_reload_w1", 32'(wq0[1]), 32'h0122);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation did not finish");
  end

endmodule
